hdmi_mode_sched: RTL and testbench

//  Frame-synchronous scheduler selecting the active processing mode of the HDMI pipeline.

---
 rtl/hdmi_sched_pkg.sv | 20 ++
 rtl/hdmi_mode_sched_key_debounce.sv | 45 ++++
 rtl/hdmi_mode_sched.sv | 115 +++++++++++
 tb/tb_hdmi_mode_sched.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/hdmi_sched_pkg.sv
// Shared types and width helpers for the HDMI mode scheduler.
// Imported by the scheduler top and its key debouncer.
package hdmi_sched_pkg;

    typedef enum logic [1:0] {
        AUTO,
        HOLD,
        PAUSED
    } sched_state_t;

    localparam int MIN_CNT_W = 1;

    // Width able to hold 0..max_v, never narrower than one bit.
    function automatic int cnt_w(input int max_v);
        if (max_v < 1)
            return MIN_CNT_W;
        return $clog2(max_v + 1);
    endfunction

endpackage

// File: rtl/hdmi_mode_sched_key_debounce.sv
// Key synchroniser and debouncer for the manual mode-advance button.
// Emits a single-cycle press pulse per accepted released->pressed edge.
module key_debounce
    import hdmi_sched_pkg::*;
#(
    parameter int CYC = 1000000
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic key_n_i,
    output logic press_o
);

    localparam int CW = cnt_w(CYC - 1);

    logic          s1;
    logic          s2;
    logic          stable;
    logic [CW-1:0] cnt;

    // cnt tracks how many consecutive samples disagree with the accepted level.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            s1      <= 1'b1;
            s2      <= 1'b1;
            stable  <= 1'b1;
            cnt     <= '0;
            press_o <= 1'b0;
        end else begin
            s1      <= key_n_i;
            s2      <= s1;
            press_o <= 1'b0;
            if (s2 == stable) begin
                cnt <= '0;
            end else if (cnt == CW'(CYC - 1)) begin
                stable  <= s2;
                cnt     <= '0;
                press_o <= ~s2;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/hdmi_mode_sched.sv
// Frame-synchronous processing-mode scheduler for the HDMI pipeline.
// Auto-cycles modes, with manual advance + hold and a pause level.
module hdmi_mode_sched
    import hdmi_sched_pkg::*;
#(
    parameter int N_MODES         = 4,
    parameter int FRAMES_PER_MODE = 120,
    parameter int HOLD_FRAMES     = 600,
    parameter int DEBOUNCE_CYC    = 1000000
) (
    input  logic                       clk_i,
    input  logic                       rst_n_i,
    input  logic                       vsync_i,
    input  logic                       key_n_i,
    input  logic                       pause_i,
    output logic [N_MODES-1:0]         mode_o,
    output logic [$clog2(N_MODES)-1:0] mode_idx_o,
    output logic                       frame_start_o,
    output logic                       hold_o
);

    localparam int IW = $clog2(N_MODES);
    localparam int FW = cnt_w(FRAMES_PER_MODE - 1);
    localparam int HW = cnt_w(HOLD_FRAMES - 1);

    sched_state_t  state;
    logic          vs_q;
    logic          fs;
    logic          press;
    logic          pend;
    logic          pend_now;
    logic [FW-1:0] frm_cnt;
    logic [HW-1:0] hold_cnt;
    logic [IW-1:0] idx_nx;
    logic [N_MODES-1:0] mode_nx;

    key_debounce #(
        .CYC(DEBOUNCE_CYC)
    ) u_key (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .key_n_i (key_n_i),
        .press_o (press)
    );

    assign fs       = vsync_i & ~vs_q;
    // A press landing on the frame-start cycle is honoured by that frame.
    assign pend_now = pend | press;
    assign idx_nx   = (mode_idx_o == IW'(N_MODES - 1)) ? '0
                                                       : mode_idx_o + IW'(1);
    assign mode_nx  = N_MODES'(1) << idx_nx;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            vs_q          <= 1'b0;
            frame_start_o <= 1'b0;
            pend          <= 1'b0;
            state         <= AUTO;
            frm_cnt       <= '0;
            hold_cnt      <= '0;
            mode_idx_o    <= '0;
            mode_o        <= N_MODES'(1);
            hold_o        <= 1'b0;
        end else begin
            vs_q          <= vsync_i;
            frame_start_o <= fs;
            pend          <= fs ? 1'b0 : pend_now;
            if (fs) begin
                unique case (state)
                    AUTO, PAUSED: begin
                        if (pend_now) begin
                            mode_idx_o <= idx_nx;
                            mode_o     <= mode_nx;
                            frm_cnt    <= '0;
                            hold_cnt   <= HW'(HOLD_FRAMES - 1);
                            state      <= HOLD;
                            hold_o     <= 1'b1;
                        end else if (state == PAUSED) begin
                            if (!pause_i) begin
                                state   <= AUTO;
                                frm_cnt <= '0;
                            end
                        end else if (pause_i) begin
                            state <= PAUSED;
                        end else if (frm_cnt == FW'(FRAMES_PER_MODE - 1)) begin
                            mode_idx_o <= idx_nx;
                            mode_o     <= mode_nx;
                            frm_cnt    <= '0;
                        end else begin
                            frm_cnt <= frm_cnt + FW'(1);
                        end
                    end
                    HOLD: begin
                        if (pend_now) begin
                            mode_idx_o <= idx_nx;
                            mode_o     <= mode_nx;
                            hold_cnt   <= HW'(HOLD_FRAMES - 1);
                        end else if (hold_cnt == '0) begin
                            frm_cnt <= '0;
                            state   <= pause_i ? PAUSED : AUTO;
                            hold_o  <= 1'b0;
                        end else begin
                            hold_cnt <= hold_cnt - HW'(1);
                        end
                    end
                    default: begin
                        state  <= AUTO;
                        hold_o <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_hdmi_mode_sched.sv
// Directed bench for hdmi_mode_sched with short frames and fast debounce.
// Expected mode sequences are hand-derived from the scheduling rules.
module tb_hdmi_mode_sched;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       vsync = 1'b0;
    logic       key_n = 1'b1;
    logic       pause = 1'b0;
    logic [3:0] mode;
    logic [1:0] idx;
    logic       fstart;
    logic       hold;

    int checks = 0;
    int errors = 0;
    int pulses;

    always #5 clk = ~clk;

    hdmi_mode_sched #(
        .N_MODES         (4),
        .FRAMES_PER_MODE (3),
        .HOLD_FRAMES     (2),
        .DEBOUNCE_CYC    (4)
    ) dut (
        .clk_i         (clk),
        .rst_n_i       (rst_n),
        .vsync_i       (vsync),
        .key_n_i       (key_n),
        .pause_i       (pause),
        .mode_o        (mode),
        .mode_idx_o    (idx),
        .frame_start_o (fstart),
        .hold_o        (hold)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic expect_st(input string tag, input int i, input bit h);
        check({tag, "_idx"}, 32'(idx), 32'(i));
        check({tag, "_mode"}, 32'(mode), 32'(1) << i);
        check({tag, "_hold"}, 32'(hold), 32'(h));
    endtask

    task automatic frame();
        @(negedge clk) vsync = 1'b1;
        @(negedge clk) vsync = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic press();
        @(negedge clk) key_n = 1'b0;
        repeat (10) @(negedge clk);
        key_n = 1'b1;
        repeat (10) @(negedge clk);
    endtask

    task automatic key_for(input logic lvl, input int n);
        key_n = lvl;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        expect_st("reset", 0, 1'b0);
        check("reset_fs", 32'(fstart), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Auto: advance on every third frame start, wrapping at 4 modes.
        for (int k = 1; k <= 12; k++) begin
            frame();
            expect_st($sformatf("auto%0d", k), (k / 3) % 4, 1'b0);
        end

        // Long vsync: exactly one single-cycle frame start.
        frame();
        frame();
        expect_st("edge_pre", 0, 1'b0);
        @(negedge clk) vsync = 1'b1;
        pulses = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (i == 0)
                check("edge_first", 32'(fstart), 32'd1);
            if (fstart) begin
                pulses++;
                check("edge_idx_at_fs", 32'(idx), 32'd1);
            end
        end
        vsync = 1'b0;
        repeat (4) @(negedge clk);
        check("edge_pulses", 32'(pulses), 32'd1);
        expect_st("edge_post", 1, 1'b0);

        // Bouncy manual press mid-frame.
        @(negedge clk);
        key_for(1'b0, 3);
        key_for(1'b1, 3);
        key_for(1'b0, 3);
        key_for(1'b1, 3);
        key_for(1'b0, 10);
        key_for(1'b1, 10);
        expect_st("man_pre", 1, 1'b0);
        frame();
        expect_st("man_a", 2, 1'b1);
        frame();
        expect_st("man_b", 2, 1'b1);
        frame();
        expect_st("man_c", 2, 1'b0);
        frame();
        expect_st("man_d", 2, 1'b0);
        frame();
        expect_st("man_e", 2, 1'b0);
        frame();
        expect_st("man_f", 3, 1'b0);

        // Three presses in one frame collapse into a single advance.
        press();
        press();
        press();
        frame();
        expect_st("col_g", 0, 1'b1);
        frame();
        expect_st("col_h", 0, 1'b1);
        press();
        frame();
        expect_st("col_i", 1, 1'b1);
        frame();
        expect_st("col_j", 1, 1'b1);
        frame();
        expect_st("col_k", 1, 1'b0);

        // Pause freezes auto-cycling; a press still advances and holds.
        pause = 1'b1;
        for (int k = 0; k < 11; k++) begin
            frame();
            expect_st($sformatf("pause%0d", k), 1, 1'b0);
        end
        press();
        frame();
        expect_st("pz_hold_a", 2, 1'b1);
        frame();
        expect_st("pz_hold_b", 2, 1'b1);
        frame();
        expect_st("pz_back", 2, 1'b0);
        frame();
        expect_st("pz_still", 2, 1'b0);
        pause = 1'b0;
        frame();
        expect_st("pz_auto0", 2, 1'b0);
        frame();
        expect_st("pz_auto1", 2, 1'b0);
        frame();
        expect_st("pz_auto2", 2, 1'b0);
        frame();
        expect_st("pz_auto3", 3, 1'b0);

        // Reset in HOLD with a press pending.
        press();
        frame();
        expect_st("rst_h0", 0, 1'b1);
        press();
        frame();
        expect_st("rst_h1", 1, 1'b1);
        press();
        @(negedge clk) rst_n = 1'b0;
        #1;
        expect_st("rst_mid", 0, 1'b0);
        check("rst_fs", 32'(fstart), 32'd0);
        @(negedge clk) rst_n = 1'b1;
        repeat (2) @(negedge clk);
        frame();
        expect_st("rst_after", 0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
